// File: rtl/red_leds_pwm_sequencer_if.sv
// Control-word / LED-drive bundle between the PIO register side and the LED sequencer.
// The master owns the control word; the slave (sequencer) owns the LED drive and frame strobe.
interface red_leds_pwm_sequencer_if #(
   parameter int NUM_LEDS = 18
);
   logic [31:0]         led_word;
   logic [NUM_LEDS-1:0] ledr;
   logic                frame_strobe;

   modport master (output led_word, input ledr, frame_strobe);
   modport slave  (input led_word, output ledr, frame_strobe);
endinterface

// File: rtl/red_leds_pwm_sequencer.sv
// Red-LED driver: 8-bit PWM brightness with static/blink/chase patterns.
// The control word is latched only at PWM frame boundaries so host writes never glitch a frame.
module red_leds_pwm_sequencer #(
   parameter int NUM_LEDS = 18,
   parameter int PRESCALE = 50
) (
   input  logic                   clk,
   input  logic                   reset,
   red_leds_pwm_sequencer_if.slave bus
);
   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [7:0]          pwm_q, pwm_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic                phase_q, phase_d;
   logic [NUM_LEDS-1:0] rot_q, rot_d;
   logic [31:0]         active_q, active_d;
   logic [NUM_LEDS-1:0] ledr_q, ledr_d;
   logic                strobe_q, strobe_d;

   logic                tick;
   logic                wrap;
   logic [NUM_LEDS-1:0] mask;
   logic [NUM_LEDS-1:0] pattern;
   logic [7:0]          duty;
   mode_e               mode;
   logic [3:0]          rate;
   logic [15:0]         fcnt_last;
   logic                gate;

   function automatic logic [NUM_LEDS-1:0] rotl1(input logic [NUM_LEDS-1:0] v);
      return {v[NUM_LEDS-2:0], v[NUM_LEDS-1]};
   endfunction

   always_comb begin
      mask      = active_q[NUM_LEDS-1:0];
      duty      = active_q[25:18];
      mode      = mode_e'(active_q[27:26]);
      rate      = active_q[31:28];
      fcnt_last = (16'd1 << rate) - 16'd1;

      tick = (pre_q == PRE_LAST);
      wrap = tick && (pwm_q == 8'hFF);

      pre_d    = tick ? '0 : pre_q + PRE_W'(1);
      pwm_d    = tick ? pwm_q + 8'd1 : pwm_q;
      strobe_d = wrap;
      active_d = active_q;
      fcnt_d   = fcnt_q;
      phase_d  = phase_q;
      rot_d    = rot_q;

      // A changed word at the boundary is a load and pre-empts any pending step.
      if (wrap) begin
         active_d = bus.led_word;
         if (bus.led_word != active_q) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
            rot_d   = bus.led_word[NUM_LEDS-1:0];
         end else if (fcnt_q == fcnt_last) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
            rot_d   = rotl1(rot_q);
         end else begin
            fcnt_d  = fcnt_q + 16'd1;
         end
      end

      case (mode)
         MODE_BLINK: pattern = phase_q ? '0 : mask;
         MODE_CHASE: pattern = rot_q;
         default:    pattern = mask;
      endcase

      gate   = (duty == 8'hFF) || (pwm_q < duty);
      ledr_d = pattern & {NUM_LEDS{gate}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q    <= '0;
         pwm_q    <= '0;
         fcnt_q   <= '0;
         phase_q  <= 1'b0;
         rot_q    <= '0;
         active_q <= '0;
         ledr_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         pwm_q    <= pwm_d;
         fcnt_q   <= fcnt_d;
         phase_q  <= phase_d;
         rot_q    <= rot_d;
         active_q <= active_d;
         ledr_q   <= ledr_d;
         strobe_q <= strobe_d;
      end
   end

   assign bus.ledr         = ledr_q;
   assign bus.frame_strobe = strobe_q;
endmodule

// File: tb/tb_red_leds_pwm_sequencer.sv
// Directed bench for red_leds_pwm_sequencer with PRESCALE=2 (512-cycle frames).
// Each frame is checked cycle by cycle against hand-derived ledr/frame_strobe expectations.
module tb_red_leds_pwm_sequencer;
   localparam int N        = 18;
   localparam int PRESCALE = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   red_leds_pwm_sequencer_if #(.NUM_LEDS(N)) bus ();

   red_leds_pwm_sequencer #(.NUM_LEDS(N), .PRESCALE(PRESCALE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called in the strobe cycle of a frame; i is the offset from that cycle.
   // ledr at offset i reflects pwm=(i-1)/PRESCALE; offset 0 still shows the previous frame's last value.
   task automatic chk_span(input string tag, input logic [N-1:0] prev_last, input logic [N-1:0] pat,
                           input logic [7:0] duty, input int i0, input int i1);
      for (int i = i0; i <= i1; i++) begin
         logic [N-1:0] exp;
         int           pwm;
         if (i == 0) begin
            exp = prev_last;
         end else begin
            pwm = (i - 1) / PRESCALE;
            exp = ((duty == 8'hFF) || (pwm < int'(duty))) ? pat : '0;
         end
         check($sformatf("%s.ledr[%0d]", tag, i), 32'(bus.ledr), 32'(exp));
         check($sformatf("%s.strobe[%0d]", tag, i), 32'(bus.frame_strobe), (i == 0) ? 32'd1 : 32'd0);
         adv(1);
      end
   endtask

   task automatic chk_idle(input string tag);
      for (int i = 0; i < 256 * PRESCALE; i++) begin
         check($sformatf("%s.ledr[%0d]", tag, i), 32'(bus.ledr), 32'd0);
         check($sformatf("%s.strobe[%0d]", tag, i), 32'(bus.frame_strobe), 32'd0);
         adv(1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.led_word = 32'h00101010;
      adv(3);
      check("rst.ledr", 32'(bus.ledr), 32'd0);
      check("rst.strobe", 32'(bus.frame_strobe), 32'd0);

      // Static, duty 4: 8 lit cycles per frame.
      reset = 1'b0;
      chk_idle("t1_idle");
      chk_span("t1_f0", 18'h0, 18'h01010, 8'd4, 0, 511);
      chk_span("t1_f1", 18'h0, 18'h01010, 8'd4, 0, 511);

      // Full duty: continuous drive across frames.
      bus.led_word = 32'h03FFFFFF;
      chk_span("t2_old", 18'h0, 18'h01010, 8'd4, 0, 511);
      chk_span("t2_load", 18'h0, 18'h3FFFF, 8'hFF, 0, 511);
      chk_span("t2_hold", 18'h3FFFF, 18'h3FFFF, 8'hFF, 0, 511);

      // Mid-frame write is deferred to the next boundary.
      bus.led_word = 32'h03FC0001;
      chk_span("t3_old", 18'h3FFFF, 18'h3FFFF, 8'hFF, 0, 511);
      chk_span("t3_load", 18'h3FFFF, 18'h00001, 8'hFF, 0, 255);
      bus.led_word = 32'h03FC0002;
      chk_span("t3_mid", 18'h3FFFF, 18'h00001, 8'hFF, 256, 511);
      chk_span("t3_new", 18'h00001, 18'h00002, 8'hFF, 0, 511);

      // Blink at rate 1: two frames on, two off.
      bus.led_word = 32'h17FC0001;
      chk_span("t4_old", 18'h00002, 18'h00002, 8'hFF, 0, 511);
      chk_span("t4_on0", 18'h00002, 18'h00001, 8'hFF, 0, 511);
      chk_span("t4_on1", 18'h00001, 18'h00001, 8'hFF, 0, 511);
      chk_span("t4_off0", 18'h00001, 18'h00000, 8'hFF, 0, 511);
      chk_span("t4_off1", 18'h00000, 18'h00000, 8'hFF, 0, 511);
      chk_span("t4_on2", 18'h00000, 18'h00001, 8'hFF, 0, 511);

      // Chase at rate 0; the load lands while blink's step condition is also true.
      bus.led_word = 32'h0BFE0000;
      chk_span("t5_old", 18'h00001, 18'h00001, 8'hFF, 0, 511);
      chk_span("t5_load", 18'h00001, 18'h20000, 8'hFF, 0, 511);
      chk_span("t5_step1", 18'h20000, 18'h00001, 8'hFF, 0, 511);
      chk_span("t5_step2", 18'h00001, 18'h00002, 8'hFF, 0, 255);
      bus.led_word = 32'h0BFE0000;
      chk_span("t5_rewr", 18'h00001, 18'h00002, 8'hFF, 256, 511);
      chk_span("t5_step3", 18'h00002, 18'h00004, 8'hFF, 0, 199);

      // One-cycle reset mid-chase restarts everything.
      reset = 1'b1;
      adv(1);
      check("t6_rst.ledr", 32'(bus.ledr), 32'd0);
      check("t6_rst.strobe", 32'(bus.frame_strobe), 32'd0);
      reset = 1'b0;
      chk_idle("t6_idle");
      chk_span("t6_load", 18'h00000, 18'h20000, 8'hFF, 0, 511);
      chk_span("t6_step", 18'h20000, 18'h00001, 8'hFF, 0, 511);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
